// File: rtl/digest_accumulator.sv
// ============================================================================
//  Module   : digest_accumulator
//  Purpose  : SHA-256 chaining-hash accumulator with serialized digest output.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module digest_accumulator #(
   parameter int WORD_W = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              load_iv,
   input  logic [WORD_W-1:0] iv_A,
   input  logic [WORD_W-1:0] iv_B,
   input  logic [WORD_W-1:0] iv_C,
   input  logic [WORD_W-1:0] iv_D,
   input  logic [WORD_W-1:0] iv_E,
   input  logic [WORD_W-1:0] iv_F,
   input  logic [WORD_W-1:0] iv_G,
   input  logic [WORD_W-1:0] iv_H,
   input  logic              round_done,
   input  logic [WORD_W-1:0] wv_a,
   input  logic [WORD_W-1:0] wv_b,
   input  logic [WORD_W-1:0] wv_c,
   input  logic [WORD_W-1:0] wv_d,
   input  logic [WORD_W-1:0] wv_e,
   input  logic [WORD_W-1:0] wv_f,
   input  logic [WORD_W-1:0] wv_g,
   input  logic [WORD_W-1:0] wv_h,
   input  logic              last_block,
   output logic              busy,
   output logic [WORD_W-1:0] hash_A,
   output logic [WORD_W-1:0] hash_B,
   output logic [WORD_W-1:0] hash_C,
   output logic [WORD_W-1:0] hash_D,
   output logic [WORD_W-1:0] hash_E,
   output logic [WORD_W-1:0] hash_F,
   output logic [WORD_W-1:0] hash_G,
   output logic [WORD_W-1:0] hash_H,
   output logic [WORD_W-1:0] dout,
   output logic              dout_valid,
   input  logic              dout_ready,
   output logic              dout_last
);

   localparam logic [1:0] c_IDLE  = 2'd0;
   localparam logic [1:0] c_ACCUM = 2'd1;
   localparam logic [1:0] c_OUT   = 2'd2;

   logic [1:0]        state_q, state_d;
   logic [2:0]        idx_q, idx_d;
   logic [WORD_W-1:0] hash_q [8];
   logic [WORD_W-1:0] hash_d [8];
   logic [WORD_W-1:0] w_iv   [8];
   logic [WORD_W-1:0] w_wv   [8];

   assign w_iv[0] = iv_A;  assign w_iv[1] = iv_B;
   assign w_iv[2] = iv_C;  assign w_iv[3] = iv_D;
   assign w_iv[4] = iv_E;  assign w_iv[5] = iv_F;
   assign w_iv[6] = iv_G;  assign w_iv[7] = iv_H;

   assign w_wv[0] = wv_a;  assign w_wv[1] = wv_b;
   assign w_wv[2] = wv_c;  assign w_wv[3] = wv_d;
   assign w_wv[4] = wv_e;  assign w_wv[5] = wv_f;
   assign w_wv[6] = wv_g;  assign w_wv[7] = wv_h;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= c_IDLE;
         idx_q   <= 3'd0;
         for (int i = 0; i < 8; i++) hash_q[i] <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         for (int i = 0; i < 8; i++) hash_q[i] <= hash_d[i];
      end
   end

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      for (int i = 0; i < 8; i++) hash_d[i] = hash_q[i];
      case (state_q)
         c_IDLE: begin
            if (load_iv) begin
               for (int i = 0; i < 8; i++) hash_d[i] = w_iv[i];
               state_d = c_ACCUM;
            end
         end
         c_ACCUM: begin
            // A reload takes priority and swallows a coincident round_done.
            if (load_iv) begin
               for (int i = 0; i < 8; i++) hash_d[i] = w_iv[i];
            end else if (round_done) begin
               for (int i = 0; i < 8; i++) hash_d[i] = hash_q[i] + w_wv[i];
               if (last_block) begin
                  state_d = c_OUT;
                  idx_d   = 3'd0;
               end
            end
         end
         c_OUT: begin
            if (dout_ready) begin
               if (idx_q == 3'd7) begin
                  state_d = c_IDLE;
                  idx_d   = 3'd0;
               end else begin
                  idx_d = idx_q + 3'd1;
               end
            end
         end
         default: begin
            state_d = c_IDLE;
            idx_d   = 3'd0;
         end
      endcase
   end

   always_comb begin
      busy       = (state_q == c_ACCUM) || (state_q == c_OUT);
      dout_valid = (state_q == c_OUT);
      dout_last  = (state_q == c_OUT) && (idx_q == 3'd7);
      dout       = (state_q == c_OUT) ? hash_q[idx_q] : '0;
   end

   assign hash_A = hash_q[0];
   assign hash_B = hash_q[1];
   assign hash_C = hash_q[2];
   assign hash_D = hash_q[3];
   assign hash_E = hash_q[4];
   assign hash_F = hash_q[5];
   assign hash_G = hash_q[6];
   assign hash_H = hash_q[7];

endmodule

`default_nettype wire

// File: tb/tb_digest_accumulator.sv
// ============================================================================
//  Module   : tb_digest_accumulator
//  Purpose  : Scoreboard bench for digest_accumulator using directed vectors.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module tb_digest_accumulator;

   typedef struct {
      logic [31:0] w;
      logic        last;
   } exp_t;

   logic        clk;
   logic        rst_n;
   logic        load_iv;
   logic        round_done;
   logic        last_block;
   logic        dout_ready;
   logic [31:0] iv [8];
   logic [31:0] wv [8];
   logic        busy;
   logic        dout_valid;
   logic        dout_last;
   logic [31:0] dout;
   logic [31:0] hash_A, hash_B, hash_C, hash_D, hash_E, hash_F, hash_G, hash_H;

   exp_t sb[$];
   int   n_checks = 0;
   int   n_fail   = 0;

   digest_accumulator #(.WORD_W(32)) dut (
      .clk(clk), .rst_n(rst_n), .load_iv(load_iv),
      .iv_A(iv[0]), .iv_B(iv[1]), .iv_C(iv[2]), .iv_D(iv[3]),
      .iv_E(iv[4]), .iv_F(iv[5]), .iv_G(iv[6]), .iv_H(iv[7]),
      .round_done(round_done),
      .wv_a(wv[0]), .wv_b(wv[1]), .wv_c(wv[2]), .wv_d(wv[3]),
      .wv_e(wv[4]), .wv_f(wv[5]), .wv_g(wv[6]), .wv_h(wv[7]),
      .last_block(last_block), .busy(busy),
      .hash_A(hash_A), .hash_B(hash_B), .hash_C(hash_C), .hash_D(hash_D),
      .hash_E(hash_E), .hash_F(hash_F), .hash_G(hash_G), .hash_H(hash_H),
      .dout(dout), .dout_valid(dout_valid), .dout_ready(dout_ready),
      .dout_last(dout_last)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %08h expected %08h", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push_words(input logic [31:0] w [8]);
      for (int i = 0; i < 8; i++) sb.push_back('{w: w[i], last: (i == 7)});
   endtask

   // Monitor: checks whatever word is presented, retires it only on a transfer.
   initial begin
      forever begin
         @(negedge clk);
         if (rst_n && dout_valid) begin
            if (sb.size() == 0) begin
               chk("unexpected_word", dout, 32'hxxxxxxxx);
            end else begin
               chk("dout_word", dout, sb[0].w);
               chk("dout_last", {31'd0, dout_last}, {31'd0, sb[0].last});
               if (dout_ready) void'(sb.pop_front());
            end
         end
      end
   end

   logic [31:0] exp_w [8];

   initial begin
      rst_n = 1'b0; load_iv = 1'b0; round_done = 1'b0; last_block = 1'b0;
      dout_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin iv[i] = '0; wv[i] = '0; end
      tick(); tick();
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_valid", {31'd0, dout_valid}, 32'd0);
      chk("rst_last", {31'd0, dout_last}, 32'd0);
      chk("rst_dout", dout, 32'd0);
      chk("rst_hash_A", hash_A, 32'd0);
      chk("rst_hash_H", hash_H, 32'd0);
      rst_n = 1'b1;

      // Single block on the SHA-256 IV, every working variable = 1
      iv = '{32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
             32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};
      load_iv = 1'b1; tick(); load_iv = 1'b0;
      chk("iv_hash_A", hash_A, 32'h6a09e667);
      chk("iv_busy", {31'd0, busy}, 32'd1);
      chk("accum_valid", {31'd0, dout_valid}, 32'd0);
      for (int i = 0; i < 8; i++) wv[i] = 32'h1;
      exp_w = '{32'h6a09e668, 32'hbb67ae86, 32'h3c6ef373, 32'ha54ff53b,
                32'h510e5280, 32'h9b05688d, 32'h1f83d9ac, 32'h5be0cd1a};
      push_words(exp_w);
      round_done = 1'b1; last_block = 1'b1; tick(); round_done = 1'b0; last_block = 1'b0;
      chk("sb_hash_A", hash_A, 32'h6a09e668);
      chk("sb_hash_H", hash_H, 32'h5be0cd1a);
      chk("valid_latency", {31'd0, dout_valid}, 32'd1);
      repeat (7) tick();
      chk("last_word_busy", {31'd0, busy}, 32'd1);
      chk("last_word_flag", {31'd0, dout_last}, 32'd1);
      tick();
      chk("done_busy", {31'd0, busy}, 32'd0);
      chk("done_valid", {31'd0, dout_valid}, 32'd0);
      chk("done_sb_empty", sb.size(), 32'd0);
      chk("retain_hash_A", hash_A, 32'h6a09e668);

      // round_done in IDLE must do nothing
      round_done = 1'b1; last_block = 1'b1; tick(); round_done = 1'b0; last_block = 1'b0;
      chk("idle_rd_busy", {31'd0, busy}, 32'd0);
      chk("idle_rd_hash", hash_A, 32'h6a09e668);
      tick();
      chk("idle_rd_valid", {31'd0, dout_valid}, 32'd0);

      // Wrap-around on A, then backpressure at idx 2
      iv = '{32'hffffffff, 32'h1, 32'h2, 32'h3, 32'h4, 32'h5, 32'h6, 32'h7};
      load_iv = 1'b1; tick(); load_iv = 1'b0;
      wv = '{32'h2, 32'h100, 32'h100, 32'h100, 32'h100, 32'h100, 32'h100, 32'h100};
      exp_w = '{32'h1, 32'h101, 32'h102, 32'h103, 32'h104, 32'h105, 32'h106, 32'h107};
      push_words(exp_w);
      round_done = 1'b1; last_block = 1'b1; tick(); round_done = 1'b0; last_block = 1'b0;
      chk("wrap_hash_A", hash_A, 32'h1);
      tick(); tick();
      dout_ready = 1'b0;
      repeat (3) begin
         chk("bp_hold_dout", dout, 32'h102);
         chk("bp_hold_valid", {31'd0, dout_valid}, 32'd1);
         tick();
      end
      dout_ready = 1'b1;
      chk("bp_resume_dout", dout, 32'h102);
      repeat (6) tick();
      chk("bp_done_busy", {31'd0, busy}, 32'd0);
      chk("bp_sb_empty", sb.size(), 32'd0);

      // Simultaneous strobes: reload wins and the block stays in ACCUM
      iv = '{32'h0000abcd, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0};
      load_iv = 1'b1; tick();
      for (int i = 0; i < 8; i++) wv[i] = 32'h999;
      round_done = 1'b1; last_block = 1'b1; tick();
      load_iv = 1'b0; round_done = 1'b0; last_block = 1'b0;
      chk("simul_hash_A", hash_A, 32'h0000abcd);
      chk("simul_busy", {31'd0, busy}, 32'd1);
      chk("simul_valid", {31'd0, dout_valid}, 32'd0);

      // Chaining two blocks from a zero IV
      iv[0] = 32'h0;
      load_iv = 1'b1; tick(); load_iv = 1'b0;
      chk("reload_hash_A", hash_A, 32'h0);
      for (int i = 0; i < 8; i++) wv[i] = 32'h10;
      round_done = 1'b1; last_block = 1'b0; tick(); round_done = 1'b0;
      chk("chain1_hash_A", hash_A, 32'h10);
      chk("chain1_valid", {31'd0, dout_valid}, 32'd0);
      for (int i = 0; i < 8; i++) exp_w[i] = 32'h20;
      push_words(exp_w);
      round_done = 1'b1; last_block = 1'b1; tick(); round_done = 1'b0; last_block = 1'b0;
      chk("chain2_dout0", dout, 32'h20);

      // Reset while idx = 4 abandons the digest
      repeat (4) tick();
      chk("pre_rst_valid", {31'd0, dout_valid}, 32'd1);
      dout_ready = 1'b0; rst_n = 1'b0;
      tick();
      chk("midrst_valid", {31'd0, dout_valid}, 32'd0);
      chk("midrst_busy", {31'd0, busy}, 32'd0);
      chk("midrst_hash_A", hash_A, 32'h0);
      chk("midrst_hash_H", hash_H, 32'h0);
      chk("midrst_words_sent", 32'd8 - sb.size(), 32'd4);
      sb.delete();
      rst_n = 1'b1; dout_ready = 1'b1;
      tick(); tick();
      chk("post_rst_valid", {31'd0, dout_valid}, 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
